snake_body: RTL

SNAKE_BODY -- requirements
Module: snake_body

---
 rtl/snake_body_pkg.sv | 35 +++
 rtl/snake_body_seg_hit.sv | 23 ++
 rtl/snake_body.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/snake_body_pkg.sv
// Shared encodings for the snake body: direction codes, game states and sprite colour.
package snake_body_pkg;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'b000,
        DIR_UP    = 3'b001,
        DIR_DOWN  = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_RIGHT = 3'b100
    } dir_e;

    typedef enum logic [1:0] {
        GS_PLAY = 2'b01,
        GS_OVER = 2'b11
    } game_state_e;

    localparam logic [2:0] SNAKE_RGB = 3'b010;

    // Unused codes collapse to IDLE so they never steer the snake.
    function automatic dir_e decode_dir(input logic [2:0] raw);
        case (raw)
            3'b001:  return DIR_UP;
            3'b010:  return DIR_DOWN;
            3'b011:  return DIR_LEFT;
            3'b100:  return DIR_RIGHT;
            default: return DIR_IDLE;
        endcase
    endfunction

    function automatic logic is_reverse(input dir_e a, input dir_e b);
        return ((a == DIR_UP)   && (b == DIR_DOWN))  || ((a == DIR_DOWN)  && (b == DIR_UP)) ||
               ((a == DIR_LEFT) && (b == DIR_RIGHT)) || ((a == DIR_RIGHT) && (b == DIR_LEFT));
    endfunction

endpackage

// File: rtl/snake_body_seg_hit.sv
// Point-in-square test: is (px,py) inside the SIZE x SIZE square anchored at (sx,sy).
module seg_hit #(
    parameter int unsigned BIT  = 10,
    parameter int unsigned SIZE = 20
) (
    input  logic [BIT-1:0] px,
    input  logic [BIT-1:0] py,
    input  logic [BIT-1:0] sx,
    input  logic [BIT-1:0] sy,
    output logic           hit
);

    localparam int unsigned W = BIT + 1;

    // One extra bit keeps the square's far edge from wrapping.
    logic [W-1:0] x_end;
    logic [W-1:0] y_end;

    assign x_end = W'(sx) + W'(SIZE);
    assign y_end = W'(sy) + W'(SIZE);
    assign hit   = (px >= sx) && (W'(px) < x_end) && (py >= sy) && (W'(py) < y_end);

endmodule

// File: rtl/snake_body.sv
// Snake segment array: frame-paced movement, growth, wall/self collision and pixel hit flags.
module snake_body
    import snake_body_pkg::*;
#(
    parameter int unsigned BIT          = 10,
    parameter int unsigned SIZE         = 20,
    parameter int unsigned MAX_LEN      = 8,
    parameter int unsigned INIT_LEN     = 3,
    parameter int unsigned X_START      = 320,
    parameter int unsigned Y_START      = 240,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_SYNC_COUNT = 490,
    parameter int unsigned MOVE_DIV     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BIT-1:0]                 x_pos,
    input  logic [BIT-1:0]                 y_pos,
    input  logic [2:0]                     direction,
    input  logic [1:0]                     game_state,
    input  logic                           grow,
    output logic                           snake_head_active,
    output logic                           snake_body_active,
    output logic                           collision,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic [2:0]                     rgb
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    logic [BIT-1:0] seg_x   [MAX_LEN];
    logic [BIT-1:0] seg_y   [MAX_LEN];
    logic [BIT-1:0] seg_x_n [MAX_LEN];
    logic [BIT-1:0] seg_y_n [MAX_LEN];
    logic [BIT-1:0] init_x  [MAX_LEN];
    logic [BIT-1:0] init_y  [MAX_LEN];
    logic [LW-1:0]  length_n;
    dir_e           cur_dir, cur_dir_n, dir_in;
    logic [CW-1:0]  cnt, cnt_n;
    logic           pending, pending_n, collision_n;
    logic [BIT-1:0] head_x_n, head_y_n;
    logic [MAX_LEN-1:0] pix_hit;
    logic [MAX_LEN-1:1] self_vec;
    logic           tick, play, step, grow_eff, wall_hit, self_hit;

    // Per-segment start positions and hit testers (pixel scan and next-head compare).
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
        assign init_x[i] = BIT'(int'(X_START) - (int'(i) * int'(SIZE)));
        assign init_y[i] = BIT'(Y_START);

        seg_hit #(.BIT(BIT), .SIZE(SIZE)) u_pix (
            .px(x_pos), .py(y_pos), .sx(seg_x[i]), .sy(seg_y[i]), .hit(pix_hit[i])
        );

        if (i > 0) begin : g_self
            seg_hit #(.BIT(BIT), .SIZE(SIZE)) u_self (
                .px(head_x_n), .py(head_y_n), .sx(seg_x[i]), .sy(seg_y[i]), .hit(self_vec[i])
            );
        end
    end

    // Next-state: direction latch, frame pacing, step/collision and GAME_OVER restore.
    always_comb begin
        seg_x_n     = seg_x;
        seg_y_n     = seg_y;
        length_n    = length;
        cur_dir_n   = cur_dir;
        cnt_n       = cnt;
        pending_n   = pending | grow;
        collision_n = 1'b0;
        head_x_n    = seg_x[0];
        head_y_n    = seg_y[0];
        self_hit    = 1'b0;

        dir_in   = decode_dir(direction);
        tick     = (y_pos == BIT'(V_SYNC_COUNT)) && (x_pos == '0);
        play     = (game_state == GS_PLAY);
        step     = tick && play && (cnt == CW'(MOVE_DIV - 1)) && (cur_dir != DIR_IDLE);
        grow_eff = pending | grow;

        case (cur_dir)
            DIR_UP:    head_y_n = seg_y[0] - BIT'(SIZE);
            DIR_DOWN:  head_y_n = seg_y[0] + BIT'(SIZE);
            DIR_LEFT:  head_x_n = seg_x[0] - BIT'(SIZE);
            DIR_RIGHT: head_x_n = seg_x[0] + BIT'(SIZE);
            default:   ;
        endcase

        // Underflow past 0 wraps to a large value and trips the same bound.
        wall_hit = (head_x_n > BIT'(H_ACTIVE - SIZE)) || (head_y_n > BIT'(V_ACTIVE - SIZE));
        for (int i = 1; i < MAX_LEN; i++) begin
            if (self_vec[i] && (i <= int'(length) + int'(grow_eff) - 2)) self_hit = 1'b1;
        end

        if ((dir_in != DIR_IDLE) && !is_reverse(dir_in, cur_dir)) cur_dir_n = dir_in;

        if (tick && play) cnt_n = (cnt == CW'(MOVE_DIV - 1)) ? '0 : cnt + CW'(1);

        if (step) begin
            if (wall_hit || self_hit) begin
                collision_n = 1'b1;
            end else begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_n[i] = seg_x[i-1];
                    seg_y_n[i] = seg_y[i-1];
                end
                seg_x_n[0] = head_x_n;
                seg_y_n[0] = head_y_n;
                if (grow_eff && (length != LW'(MAX_LEN))) length_n = length + LW'(1);
                pending_n = 1'b0;
            end
        end

        if (game_state == GS_OVER) begin
            seg_x_n     = init_x;
            seg_y_n     = init_y;
            length_n    = LW'(INIT_LEN);
            cur_dir_n   = DIR_IDLE;
            cnt_n       = '0;
            pending_n   = 1'b0;
            collision_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_x     <= init_x;
            seg_y     <= init_y;
            length    <= LW'(INIT_LEN);
            cur_dir   <= DIR_IDLE;
            cnt       <= '0;
            pending   <= 1'b0;
            collision <= 1'b0;
        end else begin
            seg_x     <= seg_x_n;
            seg_y     <= seg_y_n;
            length    <= length_n;
            cur_dir   <= cur_dir_n;
            cnt       <= cnt_n;
            pending   <= pending_n;
            collision <= collision_n;
        end
    end

    // Body flag covers live segments only and yields to the head.
    always_comb begin
        snake_body_active = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (pix_hit[i] && (i < int'(length))) snake_body_active = 1'b1;
        end
        if (pix_hit[0]) snake_body_active = 1'b0;
    end

    assign snake_head_active = pix_hit[0];
    assign rgb               = SNAKE_RGB;

endmodule
